gate_truth_table_checker: RTL and testbench



---
 rtl/gate_chk_pkg.sv | 23 ++
 rtl/gate_golden_model.sv | 24 ++
 rtl/gate_truth_table_checker.sv | 180 ++++++++++++++++++
 tb/tb_gate_truth_table_checker.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate truth-table checker.
// FSM states, gate output bit positions and sweep constants.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam int GATE_AND  = 0;
    localparam int GATE_OR   = 1;
    localparam int GATE_NOTA = 2;
    localparam int GATE_NOTB = 3;
    localparam int GATE_NAND = 4;
    localparam int GATE_NOR  = 5;
    localparam int GATE_XOR  = 6;
    localparam int GATE_XNOR = 7;

    localparam int NUM_VECS = 4;

endpackage

// File: rtl/gate_golden_model.sv
// Reference outputs of the two-input gate block.
// Purely combinational; one bit per gate at its package index.
module gate_golden_model
    import gate_chk_pkg::*;
(
    input  logic       a,
    input  logic       b,
    output logic [7:0] exp
);

    // Build the expected gate vector bit by bit
    always_comb begin
        exp            = '0;
        exp[GATE_AND]  = a & b;
        exp[GATE_OR]   = a | b;
        exp[GATE_NOTA] = ~a;
        exp[GATE_NOTB] = ~b;
        exp[GATE_NAND] = ~(a & b);
        exp[GATE_NOR]  = ~(a | b);
        exp[GATE_XOR]  = a ^ b;
        exp[GATE_XNOR] = ~(a ^ b);
    end

endmodule

// File: rtl/gate_truth_table_checker.sv
// Sweeps the gate block through all a/b vectors and
// compares each settled sample against the golden model.
module gate_truth_table_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a_out,
    output logic             b_out,
    input  logic [7:0]       gate_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       first_fail_ab,
    output logic [7:0]       first_fail_mask,
    output logic             first_fail_valid
);

    localparam int WC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PC_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(SETTLE_CYCLES - 1);
    localparam logic [PC_W-1:0] PASS_LAST = PC_W'(PASSES - 1);
    localparam logic [1:0]      VEC_LAST  = 2'(NUM_VECS - 1);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be >= 1");
    end
    if (PASSES < 1) begin : g_bad_passes
        $error("PASSES must be >= 1");
    end

    state_t            state_q, state_d;
    logic [1:0]        vec_q, vec_d;
    logic [WC_W-1:0]   wait_q, wait_d;
    logic [PC_W-1:0]   pcnt_q, pcnt_d;
    logic              a_q, a_d;
    logic              b_q, b_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [1:0]        ffab_q, ffab_d;
    logic [7:0]        ffmask_q, ffmask_d;
    logic              ffv_q, ffv_d;
    logic [7:0]        exp_w;
    logic [7:0]        diff_w;

    gate_golden_model u_golden (
        .a   (a_q),
        .b   (b_q),
        .exp (exp_w)
    );

    assign diff_w = gate_in ^ exp_w;

    // Next-state and result bookkeeping for the sweep FSM
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        wait_d   = wait_q;
        pcnt_d   = pcnt_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        err_d    = err_q;
        ffab_d   = ffab_q;
        ffmask_d = ffmask_q;
        ffv_d    = ffv_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    err_d    = '0;
                    pass_d   = 1'b0;
                    ffab_d   = '0;
                    ffmask_d = '0;
                    ffv_d    = 1'b0;
                    pcnt_d   = '0;
                    vec_d    = '0;
                    wait_d   = '0;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = CHECK;
                end else begin
                    wait_d = wait_q + WC_W'(1);
                end
            end
            CHECK: begin
                if (diff_w != '0) begin
                    if (err_q != {ERR_W{1'b1}}) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (!ffv_q) begin
                        ffab_d   = {a_q, b_q};
                        ffmask_d = diff_w;
                        ffv_d    = 1'b1;
                    end
                end
                if (vec_q != VEC_LAST) begin
                    vec_d   = vec_q + 2'd1;
                    wait_d  = '0;
                    state_d = SETTLE;
                end else if (pcnt_q != PASS_LAST) begin
                    vec_d   = '0;
                    wait_d  = '0;
                    pcnt_d  = pcnt_q + PC_W'(1);
                    state_d = SETTLE;
                end else begin
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        a_d    = 1'b0;
        b_d    = 1'b0;
        if (state_d == SETTLE || state_d == CHECK) begin
            a_d = vec_d[1];
            b_d = vec_d[0];
        end
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            wait_q   <= '0;
            pcnt_q   <= '0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            ffab_q   <= '0;
            ffmask_q <= '0;
            ffv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            wait_q   <= wait_d;
            pcnt_q   <= pcnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            ffab_q   <= ffab_d;
            ffmask_q <= ffmask_d;
            ffv_q    <= ffv_d;
        end
    end

    assign a_out            = a_q;
    assign b_out            = b_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_ab    = ffab_q;
    assign first_fail_mask  = ffmask_q;
    assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench for gate_truth_table_checker.
// Three checker instances cover default, multi-pass and saturation setups.
module tb_gate_truth_table_checker;

    typedef struct {
        int         cyc;
        logic       pass;
        logic [7:0] err;
        logic [1:0] ab;
        logic [7:0] mask;
        logic       v;
    } res_t;

    localparam logic [7:0] TT [4] = '{8'hBC, 8'h56, 8'h5A, 8'h83};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start [3];
    logic       a_o [3];
    logic       b_o [3];
    logic [7:0] gin [3];
    logic       busy [3];
    logic       done [3];
    logic       pass [3];
    logic [7:0] errc [3];
    logic [1:0] ffab [3];
    logic [7:0] ffmask [3];
    logic       ffv [3];
    int         mode [3] = '{0, 0, 0};
    int         p_of [3] = '{1, 3, 70};
    int         s_of [3] = '{1, 2, 1};

    logic       ga, gb;
    logic [7:0] gexp;

    res_t       res_q [$];
    logic [1:0] ab_q [$];
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    // Stand-in gate block: 0 healthy, 1 xor stuck low, 2 all inverted
    function automatic logic [7:0] gate_blk(input logic [1:0] ab, input int m);
        logic [7:0] g;
        g = TT[ab];
        if (m == 1) g[6] = 1'b0;
        if (m == 2) g = ~g;
        return g;
    endfunction

    assign gin[0] = gate_blk({a_o[0], b_o[0]}, mode[0]);
    assign gin[1] = gate_blk({a_o[1], b_o[1]}, mode[1]);
    assign gin[2] = gate_blk({a_o[2], b_o[2]}, mode[2]);

    gate_truth_table_checker u0 (
        .clk(clk), .rst(rst), .start(start[0]),
        .a_out(a_o[0]), .b_out(b_o[0]), .gate_in(gin[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(errc[0]), .first_fail_ab(ffab[0]),
        .first_fail_mask(ffmask[0]), .first_fail_valid(ffv[0])
    );

    gate_truth_table_checker #(.SETTLE_CYCLES(2), .PASSES(3)) u1 (
        .clk(clk), .rst(rst), .start(start[1]),
        .a_out(a_o[1]), .b_out(b_o[1]), .gate_in(gin[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(errc[1]), .first_fail_ab(ffab[1]),
        .first_fail_mask(ffmask[1]), .first_fail_valid(ffv[1])
    );

    gate_truth_table_checker #(.PASSES(70)) u2 (
        .clk(clk), .rst(rst), .start(start[2]),
        .a_out(a_o[2]), .b_out(b_o[2]), .gate_in(gin[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]),
        .err_count(errc[2]), .first_fail_ab(ffab[2]),
        .first_fail_mask(ffmask[2]), .first_fail_valid(ffv[2])
    );

    gate_golden_model u_gm (.a(ga), .b(gb), .exp(gexp));

    function automatic res_t model(input int m, input int np, input int ns);
        res_t       r;
        logic [7:0] mm;
        logic [1:0] v2;
        r.cyc  = 4 * np * (ns + 1) + 1;
        r.err  = '0;
        r.ab   = '0;
        r.mask = '0;
        r.v    = 1'b0;
        for (int p = 0; p < np; p++) begin
            for (int v = 0; v < 4; v++) begin
                v2 = v[1:0];
                mm = gate_blk(v2, m) ^ TT[v2];
                if (mm != 0) begin
                    if (r.err != 8'hFF) r.err++;
                    if (!r.v) begin
                        r.ab = v2; r.mask = mm; r.v = 1'b1;
                    end
                end
            end
        end
        r.pass = (r.err == 0);
        return r;
    endfunction

    task automatic run_sweep(input int d, input int m, input int pm1, input int pm2);
        res_t       e;
        logic [1:0] eab;
        bit         seen;
        int         n;
        mode[d] = m;
        e = model(m, p_of[d], s_of[d]);
        res_q.push_back(e);
        for (int p = 0; p < p_of[d]; p++)
            for (int v = 0; v < 4; v++)
                for (int s = 0; s <= s_of[d]; s++)
                    ab_q.push_back(v[1:0]);
        start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
        seen = 0;
        for (n = 1; n <= e.cyc + 20; n++) begin
            checks++;
            if (busy[d] !== 1'b1) begin
                errors++;
                $display("FAIL busy d%0d cyc%0d: got %b want 1", d, n, busy[d]);
            end
            if (done[d] === 1'b1) begin
                seen = 1;
                break;
            end
            checks++;
            if (ab_q.size() == 0) begin
                errors++;
                $display("FAIL ab_extra d%0d cyc%0d: got %b%b want done", d, n, a_o[d], b_o[d]);
            end else begin
                eab = ab_q.pop_front();
                if ({a_o[d], b_o[d]} !== eab) begin
                    errors++;
                    $display("FAIL ab d%0d cyc%0d: got %b%b want %b", d, n, a_o[d], b_o[d], eab);
                end
            end
            start[d] = (n == pm1) || (n == pm2);
            @(posedge clk); #1;
        end
        start[d] = 1'b0;
        e = res_q.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL timeout d%0d: no done within %0d cycles", d, e.cyc + 20);
            ab_q.delete();
            return;
        end
        if (n != e.cyc) begin
            errors++;
            $display("FAIL done_cyc d%0d: got %0d want %0d", d, n, e.cyc);
        end
        checks++;
        if (ab_q.size() != 0) begin
            errors++;
            $display("FAIL ab_left d%0d: got %0d vectors unseen want 0", d, ab_q.size());
            ab_q.delete();
        end
        checks++;
        if ({a_o[d], b_o[d]} !== 2'b00) begin
            errors++;
            $display("FAIL ab_done d%0d: got %b%b want 00", d, a_o[d], b_o[d]);
        end
        checks++;
        if ({pass[d], errc[d], ffab[d], ffmask[d], ffv[d]} !== {e.pass, e.err, e.ab, e.mask, e.v}) begin
            errors++;
            $display("FAIL result d%0d: got pass=%b err=%0d ab=%b mask=%h v=%b want pass=%b err=%0d ab=%b mask=%h v=%b",
                     d, pass[d], errc[d], ffab[d], ffmask[d], ffv[d], e.pass, e.err, e.ab, e.mask, e.v);
        end
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if ({done[d], busy[d]} !== 2'b00) begin
                errors++;
                $display("FAIL idle d%0d: got done=%b busy=%b want 0 0", d, done[d], busy[d]);
            end
            checks++;
            if ({pass[d], errc[d], ffab[d], ffmask[d], ffv[d]} !== {e.pass, e.err, e.ab, e.mask, e.v}) begin
                errors++;
                $display("FAIL hold d%0d: got pass=%b err=%0d ab=%b mask=%h want pass=%b err=%0d ab=%b mask=%h",
                         d, pass[d], errc[d], ffab[d], ffmask[d], e.pass, e.err, e.ab, e.mask);
            end
        end
    endtask

    task automatic check_zero(input string nm);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({a_o[d], b_o[d], busy[d], done[d], pass[d], errc[d], ffab[d], ffmask[d], ffv[d]} !== '0) begin
                errors++;
                $display("FAIL %s d%0d: got ab=%b%b busy=%b done=%b pass=%b err=%0d ffab=%b ffmask=%h ffv=%b want all 0",
                         nm, d, a_o[d], b_o[d], busy[d], done[d], pass[d], errc[d], ffab[d], ffmask[d], ffv[d]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = '{1'b0, 1'b0, 1'b0};
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
    endtask

    task automatic test_golden();
        logic [1:0] v2;
        for (int v = 0; v < 4; v++) begin
            v2 = v[1:0];
            {ga, gb} = v2;
            #1;
            checks++;
            if (gexp !== TT[v2]) begin
                errors++;
                $display("FAIL golden ab=%b: got %h want %h", v2, gexp, TT[v2]);
            end
        end
    endtask

    task automatic test_basic();
        run_sweep(0, 0, 0, 0);
    endtask

    task automatic test_xor_stuck();
        run_sweep(0, 1, 0, 0);
    endtask

    task automatic test_multi_pass();
        run_sweep(1, 1, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_sweep(0, 0, 3, 8);
    endtask

    task automatic test_abort();
        int seen_done;
        mode[0] = 0;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy: got %b want 1", busy[0]);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("abort");
        rst = 1'b0;
        seen_done = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done[0] === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("FAIL abort_done: got %0d pulses want 0", seen_done);
        end
        run_sweep(0, 0, 0, 0);
    endtask

    task automatic test_saturate();
        run_sweep(2, 2, 0, 0);
    endtask

    initial begin
        test_reset();
        test_golden();
        test_basic();
        test_xor_stuck();
        test_multi_pass();
        test_back_to_back();
        test_abort();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
